imm_encode_seq: RTL and testbench

- Encode side of the core's immediate scheme: takes a 32-bit constant plus a target instruction kind and produces the 26-bit instruction immediate field and matching 4-bit imm_src code.
- Values that do not fit one instruction are split into an upper beat plus a lower beat.
- Sits in the debug/boot instruction injector, ahead of instruction-word assembly.
- Registered output with a valid/ready stream.

---
 rtl/imm_encode_seq.sv | 135 +++++++++++++
 tb/tb_imm_encode_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/imm_encode_seq.sv
// imm_encode_seq: encodes a 32-bit constant into a 26-bit instruction immediate field plus
// imm_src code. It streams one or two beats over valid/ready. IMM_ENC_STATS_EN adds statistics counters.
module imm_encode_seq
`ifdef IMM_ENC_STATS_EN
#(
  parameter int STAT_W = 16
)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_value,
  input  logic [1:0]  req_kind,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [25:0] out_field,
  output logic [3:0]  out_imm_src,
  output logic        out_last,
  output logic        out_err
`ifdef IMM_ENC_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_split_cnt,
  output logic [STAT_W-1:0] stat_err_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, BEAT1, BEAT2} state_t;

  state_t      state;
  logic [25:0] lo_field;
  logic [25:0] enc_field;
  logic [3:0]  enc_src;
  logic        enc_split;
  logic        enc_err;
  logic        sfit;
  logic        zfit;
  logic        hs;
  logic        accept;

  function automatic logic [25:0] c_layout(input logic [15:0] imm);
    return {imm[15:5], 4'b0000, imm[4:0], 6'b000000};
  endfunction

  assign hs        = out_valid && out_ready;
  assign req_ready = !rst && (state == IDLE || (hs && out_last));
  assign accept    = req_valid && req_ready;

  // Range checks on the upper bits: all-equal means sign-fit, all-zero means zero-extended fit.
  always_comb begin
    sfit = 1'b0;
    zfit = 1'b0;
    case (req_kind)
      2'd2: begin
        sfit = (&req_value[31:17]) | ~(|req_value[31:17]);
        zfit = ~(|req_value[31:18]);
      end
      2'd3: begin
        sfit = (&req_value[31:20]) | ~(|req_value[31:20]);
        zfit = ~(|req_value[31:21]);
      end
      default: begin
        sfit = (&req_value[31:15]) | ~(|req_value[31:15]);
        zfit = ~(|req_value[31:16]);
      end
    endcase
  end

  always_comb begin
    enc_field = '0;
    enc_src   = '0;
    enc_split = 1'b0;
    enc_err   = 1'b0;
    if (req_kind == 2'd2 && (req_value[1:0] != 2'b00 || !(sfit || zfit))) begin
      enc_err = 1'b1;
    end else if (!(sfit || zfit)) begin
      enc_split = 1'b1;
      enc_field = c_layout(req_value[31:16]);
      enc_src   = 4'b1111;
    end else begin
      enc_src = {req_kind, 1'b0, !sfit};
      case (req_kind)
        2'd0:    enc_field = {req_value[15:0], 10'd0};
        2'd1:    enc_field = c_layout(req_value[15:0]);
        2'd2:    enc_field = c_layout(req_value[17:2]);
        default: enc_field = {req_value[20:0], 5'd0};
      endcase
    end
  end

  // Accept can only coincide with the final handshake, so it takes priority over advancing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      out_field   <= '0;
      out_imm_src <= '0;
      out_last    <= 1'b0;
      out_err     <= 1'b0;
      lo_field    <= '0;
    end else if (accept) begin
      state       <= BEAT1;
      out_valid   <= 1'b1;
      out_field   <= enc_field;
      out_imm_src <= enc_src;
      out_last    <= !enc_split;
      out_err     <= enc_err;
      lo_field    <= {req_value[15:0], 10'd0};
    end else if (hs) begin
      if (state == BEAT1 && !out_last) begin
        state       <= BEAT2;
        out_field   <= lo_field;
        out_imm_src <= 4'b0001;
        out_last    <= 1'b1;
      end else begin
        state     <= IDLE;
        out_valid <= 1'b0;
      end
    end
  end

`ifdef IMM_ENC_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_split_cnt <= '0;
      stat_err_cnt   <= '0;
    end else if (accept) begin
      if (enc_split && !(&stat_split_cnt)) stat_split_cnt <= stat_split_cnt + 1'b1;
      if (enc_err && !(&stat_err_cnt))     stat_err_cnt   <= stat_err_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_imm_encode_seq.sv
// Bench for imm_encode_seq: directed and random requests against an arithmetic reference model.
module tb_imm_encode_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_value;
  logic [1:0]  req_kind;
  logic        out_valid;
  logic        out_ready;
  logic [25:0] out_field;
  logic [3:0]  out_imm_src;
  logic        out_last;
  logic        out_err;
`ifdef IMM_ENC_STATS_EN
  logic [15:0] stat_split_cnt;
  logic [15:0] stat_err_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int exp_split = 0;
  int exp_err   = 0;

  always #5 clk = ~clk;

  imm_encode_seq dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_value(req_value), .req_kind(req_kind),
    .out_valid(out_valid), .out_ready(out_ready), .out_field(out_field),
    .out_imm_src(out_imm_src), .out_last(out_last), .out_err(out_err)
`ifdef IMM_ENC_STATS_EN
    , .stat_split_cnt(stat_split_cnt), .stat_err_cnt(stat_err_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [25:0] c_lay(input longint imm);
    longint f;
    f = ((imm >> 5) << 15) | ((imm & 31) << 6);
    return f[25:0];
  endfunction

  // Beat word = {field[25:0], src[3:0], last, err}; returns the beat count.
  function automatic int model(input logic [31:0] v, input logic [1:0] k,
                               output logic [31:0] b0, output logic [31:0] b1);
    longint sx, x, w, imm, f;
    logic [3:0] s;
    sx = longint'($signed(v));
    b0 = '0;
    b1 = '0;
    w  = (k == 2'd3) ? 21 : 16;
    if (k == 2'd2 && (v % 4) != 0) begin
      b0 = {26'd0, 4'd0, 1'b1, 1'b1};
      return 1;
    end
    x = (k == 2'd2) ? sx / 4 : sx;
    if (x >= -(longint'(1) << (w - 1)) && x < (longint'(1) << (w - 1))) s = {k, 2'b00};
    else if (x >= 0 && x < (longint'(1) << w)) s = {k, 2'b01};
    else if (k == 2'd2) begin
      b0 = {26'd0, 4'd0, 1'b1, 1'b1};
      return 1;
    end else begin
      b0 = {c_lay(longint'(v) / 65536), 4'hF, 1'b0, 1'b0};
      f  = (longint'(v) % 65536) * 1024;
      b1 = {f[25:0], 4'h1, 1'b1, 1'b0};
      return 2;
    end
    imm = x & ((longint'(1) << w) - 1);
    case (k)
      2'd0:    f = imm * 1024;
      2'd3:    f = imm * 32;
      default: f = longint'(c_lay(imm));
    endcase
    b0 = {f[25:0], s, 1'b1, 1'b0};
    return 1;
  endfunction

  // Entered shortly after a negedge with the bus idle or the previous last beat on offer with out_ready=1.
  task automatic issue(input logic [31:0] v, input logic [1:0] k, input int stall, input bit chain);
    logic [31:0] b[2];
    int n;
    n = model(v, k, b[0], b[1]);
    if (n == 2) exp_split++;
    else if (b[0][0]) exp_err++;
    req_valid = 1'b1;
    req_value = v;
    req_kind  = k;
    #1 chk("req_ready_at_issue", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    req_value = $urandom;
    req_kind  = 2'($urandom_range(0, 3));
    for (int i = 0; i < n; i++) begin
      if (i == 0) begin
        repeat (stall) begin
          out_ready = 1'b0;
          #1;
          chk("beat_hold", 64'({out_valid, out_field, out_imm_src, out_last, out_err}), 64'({1'b1, b[i]}));
          chk("req_ready_stall", 64'(req_ready), 64'd0);
          @(negedge clk);
        end
      end
      out_ready = 1'b1;
      #1 chk("beat", 64'({out_valid, out_field, out_imm_src, out_last, out_err}), 64'({1'b1, b[i]}));
      if (i < n - 1) @(negedge clk);
    end
    if (!chain) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      #1 chk("idle_after", 64'(out_valid), 64'd0);
      chk("ready_idle", 64'(req_ready), 64'd1);
    end
  endtask

  task automatic chk_stats();
`ifdef IMM_ENC_STATS_EN
    chk("stat_split", 64'(stat_split_cnt), 64'(exp_split));
    chk("stat_err", 64'(stat_err_cnt), 64'(exp_err));
`endif
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] v;
    rst = 1'b1;
    req_valid = 1'b0;
    req_value = '0;
    req_kind = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", 64'({out_valid, out_field, out_imm_src, out_last, out_err}), 64'd0);
    chk("ready_in_reset", 64'(req_ready), 64'd0);
    chk_stats();
    rst = 1'b0;
    @(negedge clk);

    issue(32'h0000_1234, 2'd0, 0, 0);
    issue(32'hFFFF_8000, 2'd0, 0, 1);
    issue(32'h0000_C000, 2'd0, 0, 0);
    issue(32'h1234_5678, 2'd3, 0, 0);
    issue(32'h0000_0006, 2'd2, 0, 0);
    issue(32'h0000_0100, 2'd2, 0, 1);
    issue(32'h1234_5678, 2'd3, 5, 1);
    issue(32'h0000_7FFF, 2'd1, 0, 0);
    issue(32'h0010_0000, 2'd3, 1, 0);
    issue(32'h0020_0000, 2'd3, 0, 0);
    issue(32'h0004_0000, 2'd2, 0, 0);
    issue(32'h0003_FFFC, 2'd2, 0, 0);
    chk_stats();

    // Reset while the lower beat of a split is on offer.
    req_valid = 1'b1;
    req_value = 32'h1234_5678;
    req_kind  = 2'd3;
    out_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    #1 chk("rst_seq_beat1", 64'({out_valid, out_last, out_imm_src}), 64'({1'b1, 1'b0, 4'hF}));
    @(negedge clk);
    out_ready = 1'b0;
    #1 chk("rst_seq_beat2", 64'({out_valid, out_last, out_imm_src}), 64'({1'b1, 1'b1, 4'h1}));
    rst = 1'b1;
    #1 chk("ready_low_in_rst", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1 chk("valid_after_rst", 64'(out_valid), 64'd0);
    chk("ready_after_rst", 64'(req_ready), 64'd1);
    exp_split = 0;
    exp_err = 0;
    chk_stats();
    @(negedge clk);
    #1 chk("no_stale_beat", 64'(out_valid), 64'd0);
    issue(32'h0000_0005, 2'd1, 0, 0);

    for (int i = 0; i < 60; i++) begin
      r = $urandom;
      case ($urandom_range(0, 5))
        0: v = {{16{r[15]}}, r[15:0]};
        1: v = {16'd0, r[15:0]};
        2: v = {{11{r[20]}}, r[20:0]};
        3: v = r;
        4: v = {{14{r[17]}}, r[17:2], 2'b00};
        default: v = {14'd0, r[17:0]};
      endcase
      issue(v, 2'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end
    out_ready = 1'b1;
    @(negedge clk);
    #1 chk("final_idle", 64'(out_valid), 64'd0);
    chk_stats();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
